// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the sram-like port arbiter: request owner, access size, arbiter FSM states.
package sram_like_arbiter_pkg;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    LOCK_INST,
    LOCK_DATA
  } arb_state_e;

  function automatic arb_state_e lock_state(input owner_e o);
    return (o == OWNER_DATA) ? LOCK_DATA : LOCK_INST;
  endfunction

endpackage

// File: rtl/sram_like_arbiter_owner_fifo.sv
// In-order owner tracking FIFO, 1 bit wide; a push is taken while full if a pop frees a slot the same cycle.
module owner_fifo
  import sram_like_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  owner_e                     din,
  output owner_e                     dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  owner_e          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop)
        rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like port between inst and data requesters; responses routed in order via owner_fifo.
// Optional ARB_RR_EN: round-robin arbitration in IDLE (default fixed priority, data over inst).
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [3:0]        inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;

  arb_state_e    state;
  arb_state_e    state_next;
  owner_e        sel;
  owner_e        both_pick;
  owner_e        head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          pop_ok;
  logic          room;
  logic          handshake;

  // A response popping this cycle frees a slot for a request accepted in the same cycle.
  assign pop_ok    = mem_data_ok && !fifo_empty && !reset;
  assign room      = !fifo_full || pop_ok;
  assign handshake = mem_req && mem_addr_ok;

`ifdef ARB_RR_EN
  owner_e rr_pref;

  always_ff @(posedge clk) begin
    if (reset)
      rr_pref <= OWNER_DATA;
    else if (handshake)
      rr_pref <= (sel == OWNER_DATA) ? OWNER_INST : OWNER_DATA;
  end

  assign both_pick = rr_pref;
`else
  assign both_pick = OWNER_DATA;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (mem_req && !mem_addr_ok) state_next = lock_state(sel);
      LOCK_INST: if (!inst_req || mem_addr_ok) state_next = IDLE;
      LOCK_DATA: if (!data_req || mem_addr_ok) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // A locked address phase keeps its requester even if the other one raises req.
  always_comb begin
    sel     = OWNER_DATA;
    mem_req = 1'b0;
    unique case (state)
      IDLE: begin
        if (room) begin
          if (inst_req && data_req) begin
            sel     = both_pick;
            mem_req = 1'b1;
          end else if (data_req) begin
            sel     = OWNER_DATA;
            mem_req = 1'b1;
          end else if (inst_req) begin
            sel     = OWNER_INST;
            mem_req = 1'b1;
          end
        end
      end
      LOCK_INST: begin
        sel     = OWNER_INST;
        mem_req = inst_req;
      end
      LOCK_DATA: begin
        sel     = OWNER_DATA;
        mem_req = data_req;
      end
      default: ;
    endcase
    if (reset)
      mem_req = 1'b0;

    mem_wr    = 1'b0;
    mem_size  = '0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_req) begin
      if (sel == OWNER_DATA) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_wstrb = inst_wstrb;
        mem_addr  = inst_addr;
        mem_wdata = inst_wdata;
      end
    end

    inst_addr_ok = handshake && (sel == OWNER_INST);
    data_addr_ok = handshake && (sel == OWNER_DATA);
    inst_data_ok = pop_ok && (head == OWNER_INST);
    data_data_ok = pop_ok && (head == OWNER_DATA);
  end

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (handshake),
    .pop   (pop_ok),
    .din   (sel),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    fifo_count <= CW'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed scenarios with literal expectations, then randomized traffic vs. a queue model.
module tb_sram_like_arbiter;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req = 0, inst_wr = 0;
  logic [1:0]  inst_size = 0;
  logic [3:0]  inst_wstrb = 0;
  logic [31:0] inst_addr = 0, inst_wdata = 0;
  logic        data_req = 0, data_wr = 0;
  logic [1:0]  data_size = 0;
  logic [3:0]  data_wstrb = 0;
  logic [31:0] data_addr = 0, data_wdata = 0;
  logic        mem_addr_ok = 0, mem_data_ok = 0;
  logic [31:0] mem_rdata = 0;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;

  int tests = 0;
  int fails = 0;

  // Model state: owners of accepted-but-unanswered requests, in-flight address phase, last grant.
  bit oq[$];
  bit lk_v = 0, lk_g = 0;
  bit last_g = 0;
  bit exp_ia_ok = 0, exp_da_ok = 0;

  sram_like_arbiter #(
    .MAX_OUTSTANDING (MAX),
    .ADDR_W          (32),
    .DATA_W          (32)
  ) dut (
    .clk (clk), .reset (reset),
    .inst_req (inst_req), .inst_wr (inst_wr), .inst_size (inst_size),
    .inst_wstrb (inst_wstrb), .inst_addr (inst_addr), .inst_wdata (inst_wdata),
    .inst_addr_ok (inst_addr_ok), .inst_data_ok (inst_data_ok), .inst_rdata (inst_rdata),
    .data_req (data_req), .data_wr (data_wr), .data_size (data_size),
    .data_wstrb (data_wstrb), .data_addr (data_addr), .data_wdata (data_wdata),
    .data_addr_ok (data_addr_ok), .data_data_ok (data_data_ok), .data_rdata (data_rdata),
    .mem_req (mem_req), .mem_wr (mem_wr), .mem_size (mem_size), .mem_wstrb (mem_wstrb),
    .mem_addr (mem_addr), .mem_wdata (mem_wdata),
    .mem_addr_ok (mem_addr_ok), .mem_data_ok (mem_data_ok), .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Checks every cycle at the falling edge, then advances the model with the same inputs the DUT samples.
  always @(negedge clk) begin : model
    automatic bit mreq = 0, g = 0, room, hs, dok, dbl;
    automatic int n = oq.size();
    if (reset) begin
      chk("rst_mem_req", mem_req, 0);
      chk("rst_inst_addr_ok", inst_addr_ok, 0);
      chk("rst_data_addr_ok", data_addr_ok, 0);
      chk("rst_inst_data_ok", inst_data_ok, 0);
      chk("rst_data_data_ok", data_data_ok, 0);
      chk("rst_mem_addr", mem_addr, 0);
      oq.delete();
      lk_v = 0; last_g = 0; exp_ia_ok = 0; exp_da_ok = 0;
    end else begin
      room = (n < MAX) || (mem_data_ok && n > 0);
      dbl = inst_req && data_req;
      if (lk_v) begin
        g = lk_g;
        mreq = g ? data_req : inst_req;
      end else if (room && (inst_req || data_req)) begin
        mreq = 1;
`ifdef ARB_RR_EN
        g = dbl ? !last_g : data_req;
`else
        g = dbl ? 1'b1 : data_req;
`endif
      end
      hs  = mreq && mem_addr_ok;
      dok = mem_data_ok && (n > 0);
      chk("mem_req", mem_req, mreq);
      chk("inst_addr_ok", inst_addr_ok, hs && !g);
      chk("data_addr_ok", data_addr_ok, hs && g);
      chk("inst_data_ok", inst_data_ok, dok && (oq[0] == 1'b0));
      chk("data_data_ok", data_data_ok, dok && (oq[0] == 1'b1));
      chk("inst_rdata", inst_rdata, mem_rdata);
      chk("data_rdata", data_rdata, mem_rdata);
      if (mreq) begin
        chk("mem_addr", mem_addr, g ? data_addr : inst_addr);
        chk("mem_wr", mem_wr, g ? data_wr : inst_wr);
        chk("mem_size", mem_size, g ? data_size : inst_size);
        chk("mem_wstrb", mem_wstrb, g ? data_wstrb : inst_wstrb);
        chk("mem_wdata", mem_wdata, g ? data_wdata : inst_wdata);
      end
      if (dok) void'(oq.pop_front());
      if (hs) begin
        oq.push_back(g);
        last_g = g;
      end
      lk_v = mreq && !mem_addr_ok;
      lk_g = g;
      exp_ia_ok = hs && !g;
      exp_da_ok = hs && g;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    bit rr_exp [4];
    inst_size = 2'd2; inst_wstrb = 4'hf; data_size = 2'd2; data_wstrb = 4'hf;
    cyc(); cyc();
    #2 chk("pin_reset_mem_req", mem_req, 0);
    cyc();
    reset = 0;

    // Single inst read
    inst_req = 1; inst_addr = 32'h1c000000; mem_addr_ok = 1;
    #2 chk("pin_t1_inst_addr_ok", inst_addr_ok, 1);
    chk("pin_t1_mem_addr", mem_addr, 32'h1c000000);
    cyc();
    inst_req = 0; mem_addr_ok = 0;
    cyc();
    mem_data_ok = 1; mem_rdata = 32'h02800000;
    #2 chk("pin_t1_inst_data_ok", inst_data_ok, 1);
    chk("pin_t1_inst_rdata", inst_rdata, 32'h02800000);
    chk("pin_t1_data_data_ok", data_data_ok, 0);
    cyc();
    mem_data_ok = 0;

    // Contention: data first, then inst; responses route in the same order
    inst_req = 1; data_req = 1; data_addr = 32'h80001000; mem_addr_ok = 1;
    #2 chk("pin_t2_data_addr_ok", data_addr_ok, 1);
    chk("pin_t2_inst_addr_ok", inst_addr_ok, 0);
    chk("pin_t2_mem_addr", mem_addr, 32'h80001000);
    cyc();
    data_req = 0;
    #2 chk("pin_t2_inst_addr_ok2", inst_addr_ok, 1);
    cyc();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h11111111;
    #2 chk("pin_t2_ret1_data", data_data_ok, 1);
    chk("pin_t2_ret1_inst", inst_data_ok, 0);
    cyc();
    mem_rdata = 32'h22222222;
    #2 chk("pin_t2_ret2_inst", inst_data_ok, 1);
    chk("pin_t2_ret2_data", data_data_ok, 0);
    cyc();
    mem_data_ok = 0;

    // Lock: data address phase stalls three cycles while inst waits
    data_req = 1; data_addr = 32'h80002000; inst_req = 1; mem_addr_ok = 0;
    repeat (3) begin
      #2 chk("pin_t3_lock_addr", mem_addr, 32'h80002000);
      chk("pin_t3_lock_inst_ok", inst_addr_ok, 0);
      cyc();
    end
    mem_addr_ok = 1;
    #2 chk("pin_t3_data_addr_ok", data_addr_ok, 1);
    cyc();
    data_req = 0;
    #2 chk("pin_t3_inst_addr_ok", inst_addr_ok, 1);
    chk("pin_t3_inst_addr", mem_addr, 32'h1c000000);
    cyc();

    // Full FIFO, then push together with a pop
    inst_req = 0; data_req = 1; data_addr = 32'h80003000; mem_addr_ok = 1;
    #2 chk("pin_t4_full_mem_req", mem_req, 0);
    chk("pin_t4_full_addr_ok", data_addr_ok, 0);
    cyc();
    mem_data_ok = 1; mem_rdata = 32'h33333333;
    #2 chk("pin_t4_push_pop_addr_ok", data_addr_ok, 1);
    chk("pin_t4_push_pop_data_ok", data_data_ok, 1);
    cyc();
    data_req = 0; mem_addr_ok = 0;
    #2 chk("pin_t4_ret_inst", inst_data_ok, 1);
    cyc();
    #2 chk("pin_t4_ret_data", data_data_ok, 1);
    cyc();

    // Spurious return on an empty FIFO, then reset with two outstanding
    #2 chk("pin_t5_spur_inst", inst_data_ok, 0);
    chk("pin_t5_spur_data", data_data_ok, 0);
    cyc();
    mem_data_ok = 0; inst_req = 1; mem_addr_ok = 1;
    cyc(); cyc();
    inst_req = 0; mem_addr_ok = 0; reset = 1;
    #2 chk("pin_t5_rst_mem_req", mem_req, 0);
    cyc();
    reset = 0; mem_data_ok = 1; mem_rdata = 0;
    #2 chk("pin_t5_after_rst_inst", inst_data_ok, 0);
    chk("pin_t5_after_rst_data", data_data_ok, 0);
    cyc();

    // Continuous contention: grant order depends on the arbitration policy
`ifdef ARB_RR_EN
    rr_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    rr_exp = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    for (int i = 0; i < 4; i++) begin
      #2 chk($sformatf("pin_t6_grant%0d", i), data_addr_ok, rr_exp[i]);
      cyc();
    end
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    reset = 1;
    cyc();
    reset = 0;

    // Randomized traffic; requesters hold req and fields until accepted, rarely cancelling
    for (int c = 0; c < 4000; c++) begin
      if (inst_req && !exp_ia_ok) begin
        if ($urandom_range(0, 49) == 0) inst_req = 0;
      end else begin
        inst_req   = 1'($urandom_range(0, 1));
        inst_wr    = ($urandom_range(0, 9) == 0);
        inst_size  = 2'($urandom_range(0, 2));
        inst_wstrb = 4'($urandom);
        inst_addr  = $urandom;
        inst_wdata = $urandom;
      end
      if (data_req && !exp_da_ok) begin
        if ($urandom_range(0, 49) == 0) data_req = 0;
      end else begin
        data_req   = 1'($urandom_range(0, 1));
        data_wr    = 1'($urandom_range(0, 1));
        data_size  = 2'($urandom_range(0, 2));
        data_wstrb = 4'($urandom);
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
      mem_addr_ok = ($urandom_range(0, 9) < 6);
      mem_data_ok = ($urandom_range(0, 9) < 4);
      mem_rdata   = $urandom;
      reset       = ($urandom_range(0, 499) == 0);
      cyc();
    end
    reset = 0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
